// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings and helpers for the pipeline hazard controller
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   localparam int ZERO_REG = 0;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_MD_BUSY = 1'b1
   } md_state_e;

   // Counters whose maximum is 0 still need one bit so the flop exists.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
interface hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5
);
   logic [REG_ADDR_W-1:0] rs1_id, rs2_id, rd_ex, rs1_ex, rs2_ex, rd_mem, rd_wb;
   logic rs1_used_id, rs2_used_id, mem_read_ex, reg_write_mem, reg_write_wb;
   logic muldiv_ex, dmem_req_mem, dmem_ready, redirect_ex;
   logic stall_if, stall_id, stall_ex, stall_mem;
   logic flush_id, flush_ex, flush_mem, flush_wb;
   logic [1:0] fwd_a, fwd_b;
   logic busy;

   modport master (
      output rs1_id, rs2_id, rd_ex, rs1_ex, rs2_ex, rd_mem, rd_wb,
      output rs1_used_id, rs2_used_id, mem_read_ex, reg_write_mem, reg_write_wb,
      output muldiv_ex, dmem_req_mem, dmem_ready, redirect_ex,
      input  stall_if, stall_id, stall_ex, stall_mem,
      input  flush_id, flush_ex, flush_mem, flush_wb,
      input  fwd_a, fwd_b, busy
   );

   modport slave (
      input  rs1_id, rs2_id, rd_ex, rs1_ex, rs2_ex, rd_mem, rd_wb,
      input  rs1_used_id, rs2_used_id, mem_read_ex, reg_write_mem, reg_write_wb,
      input  muldiv_ex, dmem_req_mem, dmem_ready, redirect_ex,
      output stall_if, stall_id, stall_ex, stall_mem,
      output flush_id, flush_ex, flush_mem, flush_wb,
      output fwd_a, fwd_b, busy
   );
endinterface

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - EX operand forwarding selects, MEM result preferred over WB
module hazard_fwd_unit
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs1_ex,
   input  logic [REG_ADDR_W-1:0] rs2_ex,
   input  logic [REG_ADDR_W-1:0] rd_mem,
   input  logic                  reg_write_mem,
   input  logic [REG_ADDR_W-1:0] rd_wb,
   input  logic                  reg_write_wb,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b
);

   localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(ZERO_REG);

   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
      if (reg_write_mem && (rd_mem != ZERO) && (rd_mem == rs)) return FWD_MEM;
      if (reg_write_wb && (rd_wb != ZERO) && (rd_wb == rs))    return FWD_WB;
      return FWD_RF;
   endfunction

   assign fwd_a = fwd_sel(rs1_ex);
   assign fwd_b = fwd_sel(rs2_ex);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush sequencing for the 5-stage core: dmem wait, mul/div,
// redirect and load-use in strict priority order, plus forwarding selects
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W      = 5,
   parameter int LOAD_USE_STALLS = 1,
   parameter int MULDIV_LATENCY  = 4,
   parameter int FLUSH_EXTRA     = 0
) (
   input  logic      clk,
   input  logic      rst_n,
   hazard_ctrl_if.slave hif
);

   localparam int MD_W = cnt_w(MULDIV_LATENCY - 1);
   localparam int LU_W = cnt_w(LOAD_USE_STALLS - 1);
   localparam int FL_W = cnt_w(FLUSH_EXTRA);
   localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_LATENCY - 1);
   localparam logic [LU_W-1:0] LU_LOAD = LU_W'(LOAD_USE_STALLS - 1);
   localparam logic [FL_W-1:0] FL_LOAD = FL_W'(FLUSH_EXTRA);
   localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(ZERO_REG);

   md_state_e        state_q, state_d;
   logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
   logic [LU_W-1:0]  lu_cnt_q, lu_cnt_d;
   logic [FL_W-1:0]  fl_cnt_q, fl_cnt_d;

   logic dmem_wait, md_active, hz;
   logic s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, f_wb;

   assign dmem_wait = hif.dmem_req_mem && !hif.dmem_ready;
   assign md_active = (state_q == ST_MD_BUSY) || hif.muldiv_ex;
   assign hz = hif.mem_read_ex && (hif.rd_ex != ZERO) &&
               ((hif.rs1_used_id && (hif.rd_ex == hif.rs1_id)) ||
                (hif.rs2_used_id && (hif.rd_ex == hif.rs2_id)));

   always_comb begin
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      lu_cnt_d = lu_cnt_q;
      fl_cnt_d = fl_cnt_q;
      {s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, f_wb} = '0;
      if (dmem_wait) begin
         // Whole pipe holds; only a bubble drains into WB. Everything else freezes.
         {s_if, s_id, s_ex, s_mem, f_wb} = '1;
      end else begin
         if (lu_cnt_q != '0) lu_cnt_d = lu_cnt_q - LU_W'(1);
         if (fl_cnt_q != '0) fl_cnt_d = fl_cnt_q - FL_W'(1);
         if (md_active) begin
            {s_if, s_id, s_ex, f_mem} = '1;
            if (state_q == ST_RUN) begin
               state_d  = ST_MD_BUSY;
               md_cnt_d = MD_LOAD;
            end else begin
               if (md_cnt_q == MD_W'(1)) state_d = ST_RUN;
               if (md_cnt_q != '0) md_cnt_d = md_cnt_q - MD_W'(1);
            end
         end else if (hif.redirect_ex) begin
            {f_id, f_ex} = '1;
            fl_cnt_d = FL_LOAD;
         end else begin
            f_id = (fl_cnt_q != '0);
            if (hz || (lu_cnt_q != '0)) {s_if, s_id, f_ex} = '1;
            if (hz) lu_cnt_d = LU_LOAD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         md_cnt_q <= '0;
         lu_cnt_q <= '0;
         fl_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
         lu_cnt_q <= lu_cnt_d;
         fl_cnt_q <= fl_cnt_d;
      end
   end

   // Controls are partly combinational from inputs, so mask them while reset is held.
   assign hif.stall_if  = s_if  && rst_n;
   assign hif.stall_id  = s_id  && rst_n;
   assign hif.stall_ex  = s_ex  && rst_n;
   assign hif.stall_mem = s_mem && rst_n;
   assign hif.flush_id  = f_id  && rst_n;
   assign hif.flush_ex  = f_ex  && rst_n;
   assign hif.flush_mem = f_mem && rst_n;
   assign hif.flush_wb  = f_wb  && rst_n;
   assign hif.busy      = rst_n && ((state_q == ST_MD_BUSY) || (lu_cnt_q != '0));

   hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
      .rs1_ex        (hif.rs1_ex),
      .rs2_ex        (hif.rs2_ex),
      .rd_mem        (hif.rd_mem),
      .reg_write_mem (hif.reg_write_mem),
      .rd_wb         (hif.rd_wb),
      .reg_write_wb  (hif.reg_write_wb),
      .fwd_a         (hif.fwd_a),
      .fwd_b         (hif.fwd_b)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed checks of hazard_ctrl against a cycle model
module tb_hazard_ctrl;

   localparam int W   = 5;
   localparam int LU  = 2;
   localparam int LAT = 4;
   localparam int FE  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.REG_ADDR_W(W)) hif ();

   hazard_ctrl #(
      .REG_ADDR_W(W), .LOAD_USE_STALLS(LU), .MULDIV_LATENCY(LAT), .FLUSH_EXTRA(FE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hif   (hif)
   );

   int n_vec = 0;
   int n_err = 0;
   int m_md = 0, m_lu = 0, m_fl = 0;
   int c_sif, c_sex, c_smem, c_fid, c_fex, c_fmem, c_fwb, c_busy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [W-1:0] rs);
      if (hif.reg_write_mem && hif.rd_mem != 0 && hif.rd_mem == rs) return 2'b10;
      if (hif.reg_write_wb && hif.rd_wb != 0 && hif.rd_wb == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [8:0] obs_ctrl();
      return {hif.stall_if, hif.stall_id, hif.stall_ex, hif.stall_mem,
              hif.flush_id, hif.flush_ex, hif.flush_mem, hif.flush_wb, hif.busy};
   endfunction

   task automatic clr_in();
      {hif.rs1_id, hif.rs2_id, hif.rd_ex, hif.rs1_ex, hif.rs2_ex, hif.rd_mem, hif.rd_wb} = '0;
      {hif.rs1_used_id, hif.rs2_used_id, hif.mem_read_ex, hif.reg_write_mem, hif.reg_write_wb} = '0;
      {hif.muldiv_ex, hif.dmem_req_mem, hif.redirect_ex} = '0;
      hif.dmem_ready = 1'b1;
   endtask

   task automatic zero_cnt();
      {c_sif, c_sex, c_smem, c_fid, c_fex, c_fmem, c_fwb, c_busy} = '0;
   endtask

   // Called just after a falling edge with inputs driven; the model state
   // advances here for the coming rising edge.
   task automatic step();
      bit si, sd, se, sm, fi, fx, fm, fw, bz, hz, dw;
      int nmd, nlu, nfl;
      logic [8:0] o;
      #1;
      {si, sd, se, sm, fi, fx, fm, fw} = '0;
      bz = (m_md > 0) || (m_lu > 0);
      dw = hif.dmem_req_mem && !hif.dmem_ready;
      hz = hif.mem_read_ex && hif.rd_ex != 0 &&
           ((hif.rs1_used_id && hif.rd_ex == hif.rs1_id) ||
            (hif.rs2_used_id && hif.rd_ex == hif.rs2_id));
      if (!rst_n) begin
         bz = 0; m_md = 0; m_lu = 0; m_fl = 0;
      end else if (dw) begin
         {si, sd, se, sm, fw} = '1;
      end else begin
         nmd = m_md;
         nlu = (m_lu > 0) ? m_lu - 1 : 0;
         nfl = (m_fl > 0) ? m_fl - 1 : 0;
         if (m_md > 0 || hif.muldiv_ex) begin
            {si, sd, se, fm} = '1;
            nmd = (m_md > 0) ? m_md - 1 : LAT - 1;
         end else if (hif.redirect_ex) begin
            {fi, fx} = '1;
            nfl = FE;
         end else begin
            fi = (m_fl > 0);
            if (hz || m_lu > 0) {si, sd, fx} = '1;
            if (hz) nlu = LU - 1;
         end
         m_md = nmd; m_lu = nlu; m_fl = nfl;
      end
      o = obs_ctrl();
      chk("ctrl", 32'(o), 32'({si, sd, se, sm, fi, fx, fm, fw, bz}));
      chk("fwd", 32'({hif.fwd_a, hif.fwd_b}), 32'({ref_fwd(hif.rs1_ex), ref_fwd(hif.rs2_ex)}));
      c_sif += int'(o[8]); c_sex += int'(o[6]); c_smem += int'(o[5]);
      c_fid += int'(o[4]); c_fex += int'(o[3]); c_fmem += int'(o[2]);
      c_fwb += int'(o[1]); c_busy += int'(o[0]);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      clr_in();
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      clr_in();
      @(negedge clk);
      step();
      chk("reset_ctrl", 32'(obs_ctrl()), 32'h0);
      rst_n = 1'b1;
      idle(2);

      // 1: reset in the middle of a mul/div sequence
      hif.muldiv_ex = 1'b1; step();
      clr_in(); step();
      #1 rst_n = 1'b0;
      #1 chk("mid_reset_ctrl", 32'(obs_ctrl()), 32'h0);
      chk("mid_reset_busy", 32'(hif.busy), 32'h0);
      m_md = 0; m_lu = 0; m_fl = 0;
      @(negedge clk);
      step();
      rst_n = 1'b1;
      idle(2);

      // 2: load-use, then the same with rd_ex = x0
      zero_cnt();
      hif.mem_read_ex = 1; hif.rd_ex = 5; hif.rs1_id = 5; hif.rs1_used_id = 1; step();
      idle(4);
      chk("lu_stall_cycles", 32'(c_sif), 32'd2);
      chk("lu_flush_ex_cycles", 32'(c_fex), 32'd2);
      zero_cnt();
      hif.mem_read_ex = 1; hif.rd_ex = 0; hif.rs1_id = 0; hif.rs1_used_id = 1; step();
      idle(3);
      chk("lu_x0_stall", 32'(c_sif), 32'd0);

      // 3: mul/div, then with one dmem wait cycle inside
      zero_cnt();
      hif.muldiv_ex = 1; step();
      idle(6);
      chk("md_stall_ex", 32'(c_sex), 32'd4);
      chk("md_flush_mem", 32'(c_fmem), 32'd4);
      chk("md_busy", 32'(c_busy), 32'd3);
      zero_cnt();
      hif.muldiv_ex = 1; step();
      clr_in(); hif.dmem_req_mem = 1; hif.dmem_ready = 0; step();
      idle(6);
      chk("md_wait_stall_ex", 32'(c_sex), 32'd5);

      // 4: redirect with a same-cycle load-use hazard
      zero_cnt();
      hif.redirect_ex = 1;
      hif.mem_read_ex = 1; hif.rd_ex = 3; hif.rs2_id = 3; hif.rs2_used_id = 1; step();
      idle(5);
      chk("rd_flush_id", 32'(c_fid), 32'd3);
      chk("rd_flush_ex", 32'(c_fex), 32'd1);
      chk("rd_stall_if", 32'(c_sif), 32'd0);

      // 5: forwarding priority
      clr_in();
      hif.rd_mem = 7; hif.rd_wb = 7; hif.reg_write_mem = 1; hif.reg_write_wb = 1; hif.rs1_ex = 7;
      #1 chk("fwd_mem", 32'(hif.fwd_a), 32'h2);
      hif.reg_write_mem = 0;
      #1 chk("fwd_wb", 32'(hif.fwd_a), 32'h1);
      hif.rs1_ex = 0;
      #1 chk("fwd_rf", 32'(hif.fwd_a), 32'h0);
      @(negedge clk);

      // 6: dmem wait while a branch sits in EX
      zero_cnt();
      for (int i = 0; i < 3; i++) begin
         clr_in(); hif.dmem_req_mem = 1; hif.dmem_ready = 0; hif.redirect_ex = 1; step();
      end
      clr_in(); hif.dmem_req_mem = 1; hif.redirect_ex = 1; step();
      idle(4);
      chk("dw_stall_mem", 32'(c_smem), 32'd3);
      chk("dw_flush_wb", 32'(c_fwb), 32'd3);
      chk("dw_flush_ex", 32'(c_fex), 32'd1);
      chk("dw_flush_id", 32'(c_fid), 32'd3);

      // randomized traffic with a narrow register range to provoke hazards
      for (int i = 0; i < 2000; i++) begin
         hif.rs1_id = W'($urandom_range(0, 3)); hif.rs2_id = W'($urandom_range(0, 3));
         hif.rd_ex  = W'($urandom_range(0, 3)); hif.rs1_ex = W'($urandom_range(0, 3));
         hif.rs2_ex = W'($urandom_range(0, 3)); hif.rd_mem = W'($urandom_range(0, 3));
         hif.rd_wb  = W'($urandom_range(0, 3));
         hif.rs1_used_id = 1'($urandom); hif.rs2_used_id = 1'($urandom);
         hif.mem_read_ex = 1'($urandom); hif.reg_write_mem = 1'($urandom);
         hif.reg_write_wb = 1'($urandom);
         hif.muldiv_ex = ($urandom_range(0, 15) == 0);
         hif.redirect_ex = ($urandom_range(0, 7) == 0);
         hif.dmem_req_mem = ($urandom_range(0, 2) == 0);
         hif.dmem_ready = 1'($urandom);
         rst_n = ($urandom_range(0, 199) != 0);
         step();
      end
      rst_n = 1'b1;
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
